seq_div_multi: RTL

Parametrised iterative integer divider: unsigned or signed per transaction, configurable bits per cycle, full-range divisor, valid/ready handshake on both sides, and explicit divide-by-zero and signed-overflow reporting. It is the drop-in successor for the existing single-mode unsigned serial divider. It sits in the RGB-D VO datapath wherever a non-pipelined division per feature or pose update is acceptable.

---
 rtl/seq_div_pkg.sv | 27 ++
 rtl/seq_div_multi_if.sv | 29 ++
 rtl/seq_div_step.sv | 29 ++
 rtl/seq_div_multi.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and elaboration helpers for the iterative divider
// Purpose: state encoding, BITS_PER_CYC legality check, iteration count and counter width.
// Ports: none (package).
package seq_div_pkg;

  // One-hot so state decode for o_ready/o_valid is a single flop bit.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_CALC = 4'b0010,
    S_FIX  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

  function automatic int iter_count(input int dend_width, input int bpc);
    return dend_width / bpc;
  endfunction

  // A single-iteration configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_div_multi_if.sv
// rtl/seq_div_multi_if.sv - request/result handshake bundle of the iterative divider
// Purpose: groups request (valid/ready, mode, operands) and result (valid/ready, values, flags).
// Ports: slave = divider view, master = requester/consumer view.
interface seq_div_multi_if #(
  parameter int DEND_WIDTH = 32,
  parameter int DSOR_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_signed;
  logic [DEND_WIDTH-1:0] i_Dend;
  logic [DSOR_WIDTH-1:0] i_Dsor;
  logic                  o_valid;
  logic                  i_ready;
  logic [DEND_WIDTH-1:0] o_Quot;
  logic [DSOR_WIDTH-1:0] o_Rder;
  logic                  o_div0;
  logic                  o_ovf;

  modport slave (
    input  i_valid, i_signed, i_Dend, i_Dsor, i_ready,
    output o_ready, o_valid, o_Quot, o_Rder, o_div0, o_ovf
  );

  modport master (
    output i_valid, i_signed, i_Dend, i_Dsor, i_ready,
    input  o_ready, o_valid, o_Quot, o_Rder, o_div0, o_ovf
  );
endinterface

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step
// Purpose: shift one dividend bit into the partial remainder, trial-subtract, select.
// Ports: i_rem partial remainder in, i_dsor divisor magnitude, i_bit next dividend bit,
//        o_rem partial remainder out, o_q resolved quotient bit.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int DSOR_WIDTH = 32
) (
  input  logic [DSOR_WIDTH:0]   i_rem,
  input  logic [DSOR_WIDTH-1:0] i_dsor,
  input  logic                  i_bit,
  output logic [DSOR_WIDTH:0]   o_rem,
  output logic                  o_q
);
  localparam int RW = DSOR_WIDTH + 1;

  logic [DSOR_WIDTH:0] w_shift;
  logic [DSOR_WIDTH:0] w_diff;

  // The incoming remainder is always below the divisor, so its top bit is zero
  // and dropping it in the shift loses nothing; the extra bit keeps divisors
  // with the MSB set working.
  assign w_shift = RW'({i_rem, i_bit});
  assign w_diff  = w_shift - {1'b0, i_dsor};
  assign o_q     = (w_shift >= {1'b0, i_dsor});
  assign o_rem   = o_q ? w_diff : w_shift;

endmodule

// File: rtl/seq_div_multi.sv
// rtl/seq_div_multi.sv - iterative signed/unsigned divider, BITS_PER_CYC quotient bits per cycle
// Purpose: IDLE->CALC->FIX->DONE restoring divider with div-by-zero and signed-overflow fast path.
// Ports: i_clk clock; i_rst_n synchronous active-low reset;
//        bus (slave) request i_valid/o_ready/i_signed/i_Dend/i_Dsor,
//        result o_valid/i_ready/o_Quot/o_Rder/o_div0/o_ovf.
module seq_div_multi
  import seq_div_pkg::*;
#(
  parameter int DEND_WIDTH   = 32,
  parameter int DSOR_WIDTH   = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  seq_div_multi_if.slave bus
);
  localparam int N  = iter_count(DEND_WIDTH, BITS_PER_CYC);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [DEND_WIDTH-1:0] MOST_NEG = {1'b1, {(DEND_WIDTH-1){1'b0}}};

  if (!bpc_legal(BITS_PER_CYC) || (DEND_WIDTH % BITS_PER_CYC) != 0 ||
      DSOR_WIDTH < 2 || DSOR_WIDTH > DEND_WIDTH) begin : g_param_err
    $error("seq_div_multi: illegal DEND_WIDTH/DSOR_WIDTH/BITS_PER_CYC combination");
  end

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_signed, r_sign_q, r_sign_r;
  logic [DEND_WIDTH-1:0] r_dend;   // dividend magnitude shifts out the top, quotient in at the bottom
  logic [DSOR_WIDTH-1:0] r_dsor;
  logic [DSOR_WIDTH:0]   r_rem;
  logic [DEND_WIDTH-1:0] r_quot;
  logic [DSOR_WIDTH-1:0] r_rder;
  logic                  r_div0, r_ovf;

  logic                  w_dend_neg, w_dsor_neg, w_is_div0, w_is_ovf;
  logic [DEND_WIDTH-1:0] w_dend_mag, w_dend_nxt;
  logic [DSOR_WIDTH-1:0] w_dsor_mag, w_rem_lo;
  logic [DSOR_WIDTH:0]   w_rem [0:BITS_PER_CYC];
  logic [BITS_PER_CYC-1:0] w_qbits;

  assign w_dend_neg = bus.i_signed & bus.i_Dend[DEND_WIDTH-1];
  assign w_dsor_neg = bus.i_signed & bus.i_Dsor[DSOR_WIDTH-1];
  assign w_dend_mag = w_dend_neg ? -bus.i_Dend : bus.i_Dend;
  assign w_dsor_mag = w_dsor_neg ? -bus.i_Dsor : bus.i_Dsor;
  assign w_is_div0  = (bus.i_Dsor == '0);
  assign w_is_ovf   = bus.i_signed && (bus.i_Dend == MOST_NEG) && (&bus.i_Dsor);

  // Chain of restoring steps; the first step consumes the dividend MSB and
  // produces the most significant quotient bit of this cycle.
  assign w_rem[0] = r_rem;
  for (genvar g = 0; g < BITS_PER_CYC; g++) begin : g_step
    seq_div_step #(.DSOR_WIDTH(DSOR_WIDTH)) u_step (
      .i_rem  (w_rem[g]),
      .i_dsor (r_dsor),
      .i_bit  (r_dend[DEND_WIDTH-1-g]),
      .o_rem  (w_rem[g+1]),
      .o_q    (w_qbits[BITS_PER_CYC-1-g])
    );
  end

  always_comb begin
    w_dend_nxt = r_dend << BITS_PER_CYC;
    w_dend_nxt[BITS_PER_CYC-1:0] = w_qbits;
  end

  assign w_rem_lo = DSOR_WIDTH'(r_rem);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_valid) w_state_nxt = (w_is_div0 || w_is_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (bus.i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dend   <= '0;
      r_dsor   <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_rder   <= '0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: if (bus.i_valid) begin
          r_cnt    <= '0;
          r_signed <= bus.i_signed;
          r_sign_q <= w_dend_neg ^ w_dsor_neg;
          r_sign_r <= w_dend_neg;
          r_dend   <= w_dend_mag;
          r_dsor   <= w_dsor_mag;
          r_rem    <= '0;
          r_div0   <= w_is_div0;
          r_ovf    <= w_is_ovf;
          // Fast-path results are final at accept; normal results land in FIX.
          if (w_is_div0) begin
            r_quot <= '1;
            r_rder <= bus.i_Dend[DSOR_WIDTH-1:0];
          end else if (w_is_ovf) begin
            r_quot <= bus.i_Dend;
            r_rder <= '0;
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CW'(1);
          r_dend <= w_dend_nxt;
          r_rem  <= w_rem[BITS_PER_CYC];
        end
        S_FIX: begin
          r_quot <= (r_signed && r_sign_q) ? -r_dend : r_dend;
          r_rder <= (r_signed && r_sign_r) ? -w_rem_lo : w_rem_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_Quot  = r_quot;
  assign bus.o_Rder  = r_rder;
  assign bus.o_div0  = r_div0;
  assign bus.o_ovf   = r_ovf;

endmodule
